// File: rtl/host_ctrl_pkg.sv
// Command bytes and controller state encoding shared by the host step controller.
// ST_ACK only exists when HOST_STEP_ACK_EN is defined.
package host_ctrl_pkg;

    localparam logic [7:0] CMD_RST   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_NSTEP = 8'h4E;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_HALT  = 8'h48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_RST,
        ST_HIGH,
        ST_LOW
`ifdef HOST_STEP_ACK_EN
        , ST_ACK
`endif
    } state_e;

endpackage

// File: rtl/host_phase_timer.sv
// Loadable down-counter timing the reset, sclk-high and sclk-low phases.
// Latency: done_o is high in the Nth cycle after loading N-1.
// Backpressure: none; a load always wins over counting.
module host_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/host_step_ctrl.sv
// Decodes host command bytes into a soft reset and a manual CPU clock (single/N-step, free-run, halt).
// Latency: outputs change the cycle after the command strobe; HOST_STEP_ACK_EN adds a completion byte.
// Backpressure: none on rx; with HOST_STEP_ACK_EN the ACK state holds until ack_ready.
module host_step_ctrl
    import host_ctrl_pkg::*;
#(
    parameter int SCLK_HALF  = 4,
    parameter int RST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
`ifdef HOST_STEP_ACK_EN
    output logic       ack_valid,
    output logic [7:0] ack_data,
    input  logic       ack_ready,
`endif
    output logic       sresetn,
    output logic       sclk,
    output logic       busy,
    output logic       running,
    output logic [7:0] steps_left
);

    localparam int TMAX = (SCLK_HALF > RST_CYCLES) ? SCLK_HALF : RST_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HALF_LD = TW'(SCLK_HALF - 1);
    localparam logic [TW-1:0] RST_LD  = TW'(RST_CYCLES - 1);

    state_e     state_q, state_d;
    logic       sclk_q, sclk_d;
    logic       sresetn_q, sresetn_d;
    logic       running_q, running_d;
    logic       halt_q, halt_d;
    logic [7:0] steps_q, steps_d;
    logic [7:0] cmd_q, cmd_d;
    logic       tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;
    logic       complete, enter_rst;
    logic [7:0] done_byte;
    logic       is_rst, is_halt;

    assign is_rst  = rx_done && (rx_data == CMD_RST);
    assign is_halt = rx_done && (rx_data == CMD_HALT);

    host_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        sresetn_d = sresetn_q;
        running_d = running_q;
        halt_d    = halt_q;
        steps_d   = steps_q;
        cmd_d     = cmd_q;
        tmr_load  = 1'b0;
        tmr_val   = HALF_LD;
        complete  = 1'b0;
        enter_rst = 1'b0;
        done_byte = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    case (rx_data)
                        CMD_RST:   enter_rst = 1'b1;
                        CMD_STEP: begin
                            state_d  = ST_HIGH;
                            sclk_d   = 1'b1;
                            steps_d  = 8'd1;
                            tmr_load = 1'b1;
                            cmd_d    = CMD_STEP;
                        end
                        CMD_NSTEP: begin
                            state_d = ST_ARG;
                            cmd_d   = CMD_NSTEP;
                        end
                        CMD_GO: begin
                            state_d   = ST_HIGH;
                            sclk_d    = 1'b1;
                            running_d = 1'b1;
                            tmr_load  = 1'b1;
                            cmd_d     = CMD_GO;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ARG: begin
                if (is_rst) begin
                    enter_rst = 1'b1;
                end else if (rx_done) begin
                    if (rx_data == 8'd0) begin
                        complete = 1'b1;
                    end else begin
                        steps_d  = rx_data;
                        state_d  = ST_HIGH;
                        sclk_d   = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_RST: begin
                if (tmr_done) begin
                    sresetn_d = 1'b1;
                    complete  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (is_rst) begin
                    enter_rst = 1'b1;
                end else begin
                    if (is_halt) halt_d = 1'b1;
                    if (tmr_done) begin
                        state_d  = ST_LOW;
                        sclk_d   = 1'b0;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (is_rst) begin
                    enter_rst = 1'b1;
                end else if (tmr_done) begin
                    // A halt arriving on the last LOW cycle still stops at this boundary.
                    if (halt_q || is_halt) begin
                        running_d = 1'b0;
                        steps_d   = 8'd0;
                        halt_d    = 1'b0;
                        complete  = 1'b1;
                        done_byte = CMD_HALT;
                    end else if (!running_q && steps_q == 8'd1) begin
                        steps_d  = 8'd0;
                        complete = 1'b1;
                    end else begin
                        if (!running_q) steps_d = steps_q - 8'd1;
                        state_d  = ST_HIGH;
                        sclk_d   = 1'b1;
                        tmr_load = 1'b1;
                    end
                end else if (is_halt) begin
                    halt_d = 1'b1;
                end
            end
`ifdef HOST_STEP_ACK_EN
            ST_ACK: begin
                if (ack_ready) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Abort and fresh reset share one path; the aborted command never reports completion.
        if (enter_rst) begin
            state_d   = ST_RST;
            sclk_d    = 1'b0;
            sresetn_d = 1'b0;
            running_d = 1'b0;
            steps_d   = 8'd0;
            halt_d    = 1'b0;
            cmd_d     = CMD_RST;
            tmr_load  = 1'b1;
            tmr_val   = RST_LD;
        end

        if (complete) begin
`ifdef HOST_STEP_ACK_EN
            state_d = ST_ACK;
`else
            state_d = ST_IDLE;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 1'b0;
            sresetn_q <= 1'b1;
            running_q <= 1'b0;
            halt_q    <= 1'b0;
            steps_q   <= 8'd0;
            cmd_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            sresetn_q <= sresetn_d;
            running_q <= running_d;
            halt_q    <= halt_d;
            steps_q   <= steps_d;
            cmd_q     <= cmd_d;
        end
    end

`ifdef HOST_STEP_ACK_EN
    logic [7:0] ack_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_data_q <= 8'd0;
        end else if (complete) begin
            ack_data_q <= done_byte;
        end
    end

    assign ack_valid = (state_q == ST_ACK);
    assign ack_data  = ack_data_q;
`else
    logic unused_done_byte;
    assign unused_done_byte = ^done_byte;
`endif

    assign sclk       = sclk_q;
    assign sresetn    = sresetn_q;
    assign busy       = (state_q != ST_IDLE);
    assign running    = running_q;
    assign steps_left = steps_q;

endmodule
